register_value_uart_tx: RTL and testbench
=========================================

// Module: register_value_uart_tx
// PURPOSE
//  Consumer side of the CPU's register1Value output: watches the register, reports each new value
//  to a host as uppercase hex ASCII over a UART line (8N1), terminated by CR LF.
//  Sits beside CPU at top level; gives bring-up and PBL boards a serial view of program progress.
//  Coalescing reporter: intermediate values changing faster than a report are dropped, latest is sent.
// PARAMETERS
//  REGISTER_WIDTH  16   width of register1Value; NIBBLES = ceil(REGISTER_WIDTH/4) hex chars per report
//  CLKS_PER_BIT    434  clocks per UART bit (50 MHz / 115200); legal range >= 2
// PORTS
//  clock           in   1               single system clock, all logic on rising edge
//  isReset         in   1               asynchronous, active-low reset (0 = reset)
//  register1Value  in   REGISTER_WIDTH  CPU register under observation, sampled every clock
//  sendRequest     in   1               1-clock pulse: force a report of the current value
//  txd             out  1               UART serial output, idle high
//  busy            out  1               high from report start to end of final stop bit
//  frameCount      out  16              completed reports since reset, wraps 16'hFFFF -> 0
// BEHAVIOUR
//  Reset (isReset=0, async): txd=1, busy=0, frameCount=0, pending=1, lastSent=0, FSM=IDLE, counters 0.
//  pending set when: register1Value != lastSent (sampled each clock), or sendRequest=1, or reset.
//  pending is a single flag: any number of triggers while busy yields exactly one follow-up report.
//  IDLE: if pending -> snapshot=register1Value, lastSent=snapshot, pending cleared, busy=1, -> START.
//   Latency: trigger visible at edge N -> txd low (start bit) after edge N+1.
//  Report = NIBBLES chars (MSB nibble first, 0-9 -> 8'h30-39, A-F -> 8'h41-46), then 8'h0D, 8'h0A.
//  Per char: START (txd=0) -> DATA bits 0..7 LSB first -> STOP (txd=1), each exactly CLKS_PER_BIT clocks.
//  NEXT: char index increments; after LF stop bit -> frameCount+1, busy=0, -> IDLE same edge.
//  Back-to-back: if pending on return to IDLE, next start bit begins 1 clock later (one idle-high clock).
//  Top nibble of a non-multiple-of-4 width is zero-extended.
//  Trigger on the same edge snapshot is taken: value compares against new lastSent; sendRequest in that
//   cycle re-arms pending (one extra report).
//  Snapshot is frozen for the whole report; register1Value changes never corrupt a report in progress.
//  Reset mid-frame: txd returns high immediately (combinational from async reset state); partial char lost;
//   after release, current value is reported (pending=1).
//  Bit counter: $clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1; no fractional baud correction.
// STRUCTURE
//  Package puc_uart_pkg: txState_t enum {IDLE,START,DATA,STOP,NEXT}, ASCII_CR/ASCII_LF constants,
//   function hexAscii(input [3:0]) -> [7:0].
//  Sub-module uart_tx_byte: byte serializer (start/data in, ready/txd out, CLKS_PER_BIT param);
//   register_value_uart_tx owns change detection, pending flag, snapshot, char sequencing, frameCount.
// TESTING  (bench overrides CLKS_PER_BIT=4; UART decoder model checks bytes and bit widths)
//  1 Release reset, register1Value=16'h0000 -> "0000\r\n" (30 30 30 30 0D 0A); busy high 6*10*4=240 clocks; frameCount=1.
//  2 Idle, set 16'h1A2F -> start bit after 1 clock; bytes 31 41 32 46 0D 0A; uppercase checked.
//  3 During report set 1234, then 5678, then 9ABC -> current report intact, then exactly one "9ABC\r\n".
//  4 Idle, value unchanged, sendRequest pulse -> full report of same value; 3 pulses while busy -> one more report only.
//  5 isReset low in DATA of 2nd char -> txd=1, busy=0, frameCount=0 same cycle; release -> current value reported.
//  6 Every start/data/stop bit exactly 4 clocks; frameCount 16'hFFFF -> 16'h0000 after next report (preloaded via force).

Source files
------------

// File: rtl/puc_uart_pkg.sv
// Shared types and helpers for the register-value UART reporter.
// Holds the serializer state encoding, the CR/LF terminators and the nibble-to-ASCII mapping.
package puc_uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        NEXT  = 3'd4
    } txState_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // 0-9 map to '0'-'9', 10-15 map to uppercase 'A'-'F'
    function automatic logic [7:0] hexAscii(input logic [3:0] nibble);
        logic [7:0] ch;
        if (nibble < 4'd10) begin
            ch = 8'h30 + {4'h0, nibble};
        end else begin
            ch = 8'h37 + {4'h0, nibble};
        end
        return ch;
    endfunction

endpackage

// File: rtl/register_value_uart_tx_if.sv
// Observed-register and report-status bundle between the CPU side and the UART reporter.
interface register_value_uart_tx_if #(
    parameter int REGISTER_WIDTH = 16
);
    logic [REGISTER_WIDTH-1:0] register1Value;
    logic                      sendRequest;
    logic                      txd;
    logic                      busy;
    logic [15:0]               frameCount;

    modport master (
        output register1Value,
        output sendRequest,
        input  txd,
        input  busy,
        input  frameCount
    );

    modport slave (
        input  register1Value,
        input  sendRequest,
        output txd,
        output busy,
        output frameCount
    );
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. NEXT is the final clock of the stop bit; a start presented there
// chains the next character with no idle gap.
module uart_tx_byte
    import puc_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       isReset,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic       ready_o,
    output logic       txd_o
);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] STOP_LAST = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

    txState_t          state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              txd_q, txd_d;
    logic              bit_end_s;

    // Next-state and serial line level for the following clock
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        txd_d     = txd_q;
        bit_end_s = (baud_q == BAUD_LAST);
        case (state_q)
            IDLE, NEXT: begin
                baud_d = {BAUD_W{1'b0}};
                if (start_i) begin
                    state_d = START;
                    shift_d = data_i;
                    txd_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                    txd_d   = 1'b1;
                end
            end
            START: begin
                if (bit_end_s) begin
                    state_d = DATA;
                    baud_d  = {BAUD_W{1'b0}};
                    bit_d   = 3'd0;
                    txd_d   = shift_q[0];
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    baud_d = {BAUD_W{1'b0}};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        txd_d   = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            STOP: begin
                baud_d = baud_q + BAUD_ONE;
                if (baud_q == STOP_LAST) begin
                    state_d = NEXT;
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = {BAUD_W{1'b0}};
                txd_d   = 1'b1;
            end
        endcase
    end

    // Serializer state register; line idles high out of reset
    always_ff @(posedge clock or negedge isReset) begin
        if (!isReset) begin
            state_q <= IDLE;
            baud_q  <= {BAUD_W{1'b0}};
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

    assign ready_o = (state_q == IDLE) || (state_q == NEXT);
    assign txd_o   = txd_q;

endmodule

// File: rtl/register_value_uart_tx.sv
// Reports each new value of the observed CPU register as uppercase hex + CR LF over UART.
// Triggers coalesce into one pending flag, so only the latest value is ever reported.
module register_value_uart_tx
    import puc_uart_pkg::*;
#(
    parameter int REGISTER_WIDTH = 16,
    parameter int CLKS_PER_BIT   = 434
) (
    input  logic                   clock,
    input  logic                   isReset,
    register_value_uart_tx_if.slave rpt
);
    localparam int NIBBLES = (REGISTER_WIDTH + 3) / 4;
    localparam int PAD_W   = NIBBLES * 4;
    localparam int IDX_W   = $clog2(NIBBLES + 2);
    localparam logic [IDX_W-1:0] IDX_CR  = IDX_W'(NIBBLES);
    localparam logic [IDX_W-1:0] IDX_LF  = IDX_W'(NIBBLES + 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    logic                      pending_q, pending_d;
    logic [REGISTER_WIDTH-1:0] lastSent_q, lastSent_d;
    logic [REGISTER_WIDTH-1:0] snapshot_q, snapshot_d;
    logic [IDX_W-1:0]          charIdx_q, charIdx_d;
    logic                      busy_q, busy_d;
    logic [15:0]               frameCount_q, frameCount_d;
    logic                      ser_start_s, ser_ready_s, ser_txd_s;
    logic [7:0]                ser_data_s;
    logic [PAD_W-1:0]          src_val_s;
    logic [IDX_W-1:0]          src_idx_s;

    // Character at position idx of a report: hex digits MSB first, then CR, then LF
    function automatic logic [7:0] reportChar(input logic [PAD_W-1:0] v, input logic [IDX_W-1:0] idx);
        logic [PAD_W-1:0] sh;
        logic [7:0]       ch;
        sh = v;
        if (idx == IDX_LF) begin
            ch = ASCII_LF;
        end else if (idx == IDX_CR) begin
            ch = ASCII_CR;
        end else begin
            sh = v >> (4 * (NIBBLES - 1 - int'(idx)));
            ch = hexAscii(sh[3:0]);
        end
        return ch;
    endfunction

    // Frame sequencing, change detection and the character offered to the serializer
    always_comb begin
        pending_d    = pending_q;
        lastSent_d   = lastSent_q;
        snapshot_d   = snapshot_q;
        charIdx_d    = charIdx_q;
        busy_d       = busy_q;
        frameCount_d = frameCount_q;
        ser_start_s  = 1'b0;
        if (!busy_q) begin
            if (pending_q && ser_ready_s) begin
                snapshot_d  = rpt.register1Value;
                lastSent_d  = rpt.register1Value;
                pending_d   = 1'b0;
                busy_d      = 1'b1;
                charIdx_d   = {IDX_W{1'b0}};
                ser_start_s = 1'b1;
            end else begin
                busy_d = 1'b0;
            end
        end else if (ser_ready_s) begin
            if (charIdx_q == IDX_LF) begin
                busy_d       = 1'b0;
                frameCount_d = frameCount_q + 16'd1;
            end else begin
                charIdx_d   = charIdx_q + IDX_ONE;
                ser_start_s = 1'b1;
            end
        end else begin
            busy_d = 1'b1;
        end
        // Compared against the post-snapshot lastSent so the captured value never re-arms itself
        if ((rpt.register1Value != lastSent_d) || rpt.sendRequest) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_d;
        end
        src_val_s  = busy_q ? PAD_W'(snapshot_q) : PAD_W'(rpt.register1Value);
        src_idx_s  = busy_q ? (charIdx_q + IDX_ONE) : {IDX_W{1'b0}};
        ser_data_s = reportChar(src_val_s, src_idx_s);
    end

    // Reporter state; pending comes out of reset set so the current value is always reported
    always_ff @(posedge clock or negedge isReset) begin
        if (!isReset) begin
            pending_q    <= 1'b1;
            lastSent_q   <= {REGISTER_WIDTH{1'b0}};
            snapshot_q   <= {REGISTER_WIDTH{1'b0}};
            charIdx_q    <= {IDX_W{1'b0}};
            busy_q       <= 1'b0;
            frameCount_q <= 16'h0000;
        end else begin
            pending_q    <= pending_d;
            lastSent_q   <= lastSent_d;
            snapshot_q   <= snapshot_d;
            charIdx_q    <= charIdx_d;
            busy_q       <= busy_d;
            frameCount_q <= frameCount_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .clock   (clock),
        .isReset (isReset),
        .start_i (ser_start_s),
        .data_i  (ser_data_s),
        .ready_o (ser_ready_s),
        .txd_o   (ser_txd_s)
    );

    assign rpt.txd        = ser_txd_s;
    assign rpt.busy       = busy_q;
    assign rpt.frameCount = frameCount_q;

endmodule

// File: tb/tb_register_value_uart_tx.sv
// Bench for register_value_uart_tx at CLKS_PER_BIT=4: a UART receiver model decodes every
// character, checks each bit lasts exactly four clocks, and compares against hand-computed reports.
module tb_register_value_uart_tx;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   busy_cnt = 0;

    register_value_uart_tx_if #(.REGISTER_WIDTH(16)) bus ();

    register_value_uart_tx #(
        .REGISTER_WIDTH(16),
        .CLKS_PER_BIT  (4)
    ) dut (
        .clock  (clk),
        .isReset(rst_n),
        .rpt    (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] value;
        logic        req;
        logic [47:0] bytes;
        logic [15:0] fc;
    } vec_t;

    vec_t vecs [0:5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic rx_byte(input logic [7:0] exp_b, input string tag);
        int         waited;
        logic [39:0] s;
        logic [7:0] b;
        logic       shape_ok;
        logic       lvl;
        waited = 0;
        @(negedge clk);
        while (bus.txd !== 1'b0 && waited < 400) begin
            waited++;
            @(negedge clk);
        end
        if (bus.txd !== 1'b0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s start: no start bit within 400 clocks, required start", tag);
            return;
        end
        for (int i = 0; i < 40; i++) begin
            if (i != 0) @(negedge clk);
            s[i] = bus.txd;
            if (bus.busy === 1'b1) busy_cnt++;
        end
        for (int k = 0; k < 8; k++) b[k] = s[4*k+5];
        shape_ok = 1'b1;
        for (int j = 0; j < 10; j++) begin
            lvl = 1'b1;
            if (j == 0) lvl = 1'b0;
            else if (j < 9) lvl = b[j-1];
            for (int q = 0; q < 4; q++) if (s[4*j+q] !== lvl) shape_ok = 1'b0;
        end
        check({tag, " start latency"}, 32'(waited), 32'd0);
        check({tag, " byte"}, {24'h0, b}, {24'h0, exp_b});
        check({tag, " bit timing"}, {31'h0, shape_ok}, 32'd1);
    endtask

    task automatic rx_frame(input logic [47:0] exp_bytes, input logic [15:0] exp_fc, input string tag);
        busy_cnt = 0;
        for (int c = 0; c < 6; c++) rx_byte(exp_bytes[47-8*c -: 8], $sformatf("%s char%0d", tag, c));
        check({tag, " busy clocks"}, 32'(busy_cnt), 32'd240);
        @(negedge clk);
        check({tag, " busy after"}, {31'h0, bus.busy}, 32'd0);
        check({tag, " idle txd"}, {31'h0, bus.txd}, 32'd1);
        check({tag, " frameCount"}, {16'h0, bus.frameCount}, {16'h0, exp_fc});
    endtask

    task automatic quiet(input string tag);
        logic ok;
        ok = 1'b1;
        repeat (60) begin
            @(negedge clk);
            if (bus.txd !== 1'b1 || bus.busy !== 1'b0) ok = 1'b0;
        end
        check({tag, " no extra report"}, {31'h0, ok}, 32'd1);
    endtask

    // Apply value/request at a negedge; the line must still be high one clock later
    task automatic trigger(input logic [15:0] value, input logic req, input string tag);
        bus.register1Value = value;
        bus.sendRequest    = req;
        @(negedge clk);
        bus.sendRequest    = 1'b0;
        check({tag, " idle clock before start"}, {31'h0, bus.txd}, 32'd1);
    endtask

    initial begin
        vecs[0] = '{16'h1A2F, 1'b0, 48'h31_41_32_46_0D_0A, 16'd2};
        vecs[1] = '{16'h1A2F, 1'b1, 48'h31_41_32_46_0D_0A, 16'd3};
        vecs[2] = '{16'hFFFF, 1'b0, 48'h46_46_46_46_0D_0A, 16'd4};
        vecs[3] = '{16'h0009, 1'b0, 48'h30_30_30_39_0D_0A, 16'd5};
        vecs[4] = '{16'hC0DE, 1'b0, 48'h43_30_44_45_0D_0A, 16'd6};
        vecs[5] = '{16'h7E5A, 1'b0, 48'h37_45_35_41_0D_0A, 16'd7};

        bus.register1Value = 16'h0000;
        bus.sendRequest    = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("reset txd", {31'h0, bus.txd}, 32'd1);
        check("reset busy", {31'h0, bus.busy}, 32'd0);
        check("reset frameCount", {16'h0, bus.frameCount}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rx_frame(48'h30_30_30_30_0D_0A, 16'd1, "post-reset 0000");
        quiet("after first report");

        for (int v = 0; v < 6; v++) begin
            trigger(vecs[v].value, vecs[v].req, $sformatf("vec%0d", v));
            rx_frame(vecs[v].bytes, vecs[v].fc, $sformatf("vec%0d", v));
            quiet($sformatf("vec%0d", v));
        end

        // Three request pulses during a report collapse into a single follow-up report
        trigger(16'h7E5A, 1'b1, "req burst");
        fork
            rx_frame(48'h37_45_35_41_0D_0A, 16'd8, "req burst first");
            begin
                repeat (50) @(negedge clk);
                repeat (3) begin
                    bus.sendRequest = 1'b1;
                    @(negedge clk);
                    bus.sendRequest = 1'b0;
                    repeat (20) @(negedge clk);
                end
            end
        join
        rx_frame(48'h37_45_35_41_0D_0A, 16'd9, "req burst follow-up");
        quiet("req burst");

        // Value churn during a report: report stays intact, only the latest value follows
        trigger(16'h1111, 1'b0, "coalesce");
        fork
            rx_frame(48'h31_31_31_31_0D_0A, 16'd10, "coalesce frozen");
            begin
                repeat (40) @(negedge clk);
                bus.register1Value = 16'h1234;
                repeat (40) @(negedge clk);
                bus.register1Value = 16'h5678;
                repeat (40) @(negedge clk);
                bus.register1Value = 16'h9ABC;
            end
        join
        rx_frame(48'h39_41_42_43_0D_0A, 16'd11, "coalesce latest");
        quiet("coalesce");

        // Reset during the data bits of the second character
        trigger(16'h5A5A, 1'b0, "mid-frame reset");
        rx_byte(8'h35, "mid-frame reset char0");
        repeat (10) @(negedge clk);
        check("pre-reset txd low", {31'h0, bus.txd}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("async reset txd", {31'h0, bus.txd}, 32'd1);
        check("async reset busy", {31'h0, bus.busy}, 32'd0);
        check("async reset frameCount", {16'h0, bus.frameCount}, 32'd0);
        bus.register1Value = 16'h0C3D;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rx_frame(48'h30_43_33_44_0D_0A, 16'd1, "after reset 0C3D");
        quiet("after reset");

        // frameCount wrap from FFFF
        force dut.frameCount_q = 16'hFFFF;
        repeat (2) @(negedge clk);
        release dut.frameCount_q;
        @(negedge clk);
        check("preload frameCount", {16'h0, bus.frameCount}, 32'h0000FFFF);
        trigger(16'h0C3D, 1'b1, "wrap");
        rx_frame(48'h30_43_33_44_0D_0A, 16'd0, "wrap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
